// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin arbitrated N-channel registered mux with valid/ready handshakes.
// Optional force-select grant enabled by defining RR_ARB_MUX_FORCE_SEL_EN.
module rr_arb_mux #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef RR_ARB_MUX_FORCE_SEL_EN
    ,
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel
`endif
);
    localparam logic [SEL_W:0] CH = (SEL_W+1)'(CHANNELS);
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_g;
    logic             rr_any;
    logic [SEL_W:0]   idx;
    logic [SEL_W-1:0] g;
    logic             any;
    logic             forced;
    logic             load_en;
    assign load_en = !out_valid || out_ready;
    always_comb begin
        rr_g   = '0;
        rr_any = 1'b0;
        idx    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = {1'b0, rr_ptr} + (SEL_W+1)'(i);
            idx = (idx >= CH) ? idx - CH : idx;
            if (!rr_any && in_valid[idx[SEL_W-1:0]]) begin
                rr_any = 1'b1;
                rr_g   = idx[SEL_W-1:0];
            end
        end
    end
`ifdef RR_ARB_MUX_FORCE_SEL_EN
    // an out-of-range or idle forced channel grants nothing
    assign forced = force_en;
    assign g      = force_en ? force_sel : rr_g;
    assign any    = force_en ? (({1'b0, force_sel} < CH) && in_valid[force_sel]) : rr_any;
`else
    assign forced = 1'b0;
    assign g      = rr_g;
    assign any    = rr_any;
`endif
    assign in_ready = (reset_n && load_en && any) ? CHANNELS'(1) << g : '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            out_valid <= any;
            if (any) begin
                out_data <= in_data[g*WIDTH +: WIDTH];
                out_sel  <= g;
                if (!forced)
                    rr_ptr <= ({1'b0, g} == CH - 1'b1) ? '0 : g + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed and random checks of rr_arb_mux against a queue-free search model.
module tb_rr_arb_mux;
    localparam int C = 4;
    localparam int W = 5;
    logic           clk;
    logic           reset_n;
    logic [C*W-1:0] in_data;
    logic [C-1:0]   in_valid;
    logic [C-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_valid;
    logic           out_ready;
    bit             f_en;
    logic [1:0]     f_sel;
    int             errors;
    int             checks;
    int             m_ptr;
    logic [W-1:0]   m_data;
    logic [1:0]     m_sel;
    logic           m_valid;
    logic [C-1:0]   obs_ready;
    logic [C-1:0]   exp_ready;

    rr_arb_mux #(.WIDTH(W), .CHANNELS(C), .SEL_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef RR_ARB_MUX_FORCE_SEL_EN
        , .force_en(f_en), .force_sel(f_sel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // first valid channel at or after the fairness pointer, wrapping; -1 if none
    function automatic int model_grant();
        if (f_en) return in_valid[f_sel] ? int'(f_sel) : -1;
        for (int k = 0; k < C; k++)
            if (in_valid[(m_ptr + k) % C]) return (m_ptr + k) % C;
        return -1;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0; f_en = 1'b0; f_sel = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_ptr = 0; m_data = '0; m_sel = '0; m_valid = 1'b0;
    endtask

    task automatic tick(input logic [C-1:0] v, input logic [C*W-1:0] d, input logic rdy);
        int  g;
        bit  load;
        in_valid = v; in_data = d; out_ready = rdy;
        #1;
        obs_ready = in_ready;
        load = !m_valid || rdy;
        g = model_grant();
        exp_ready = (load && g >= 0) ? (C'(1) << g) : '0;
        @(posedge clk); #1;
        if (load) begin
            if (g >= 0) begin
                m_data = d[g*W +: W]; m_sel = 2'(g); m_valid = 1'b1;
                if (!f_en) m_ptr = (g + 1) % C;
            end else m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        in_valid = '1; #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
            errors++; $display("FAIL reset_state: valid=%b data=%h sel=%0d, want 0/00/0", out_valid, out_data, out_sel);
        end
        tick(4'b0110, {5'h04, 5'h03, 5'h02, 5'h01}, 1'b1);
        tick(4'b0100, {5'h04, 5'h03, 5'h02, 5'h01}, 1'b0);
        #2 reset_n = 1'b0; #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || in_ready !== '0) begin
            errors++; $display("FAIL reset_mid: valid=%b data=%h sel=%0d rdy=%b, want 0/00/0/0000", out_valid, out_data, out_sel, in_ready);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_ptr = 0; m_data = '0; m_sel = '0; m_valid = 1'b0;
        tick(4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 1'b1);
        checks++;
        if (out_sel !== 2'd0 || out_data !== 5'h01 || out_valid !== 1'b1) begin
            errors++; $display("FAIL reset_first_grant: sel=%0d data=%h valid=%b, want 0/01/1", out_sel, out_data, out_valid);
        end
    endtask

    task automatic test_all_valid();
        int exp_sel [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 1'b1);
            checks++;
            if (out_sel !== 2'(exp_sel[i]) || out_data !== W'(exp_sel[i] + 1) || !$onehot(obs_ready) || obs_ready !== exp_ready) begin
                errors++; $display("FAIL all_valid[%0d]: sel=%0d data=%h rdy=%b, want %0d/%h/%b", i, out_sel, out_data, obs_ready, exp_sel[i], exp_sel[i] + 1, exp_ready);
            end
        end
    endtask

    task automatic test_skip();
        int exp_sel [3] = '{3, 1, 3};
        logic [C*W-1:0] d;
        do_reset();
        d = {5'h13, 5'h12, 5'h11, 5'h10};
        tick(4'b0010, d, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(4'b1010, d, 1'b1);
            checks++;
            if (out_sel !== 2'(exp_sel[i]) || out_data !== W'(5'h10 + exp_sel[i]) || obs_ready !== (C'(1) << exp_sel[i])) begin
                errors++; $display("FAIL skip[%0d]: sel=%0d data=%h rdy=%b, want %0d", i, out_sel, out_data, obs_ready, exp_sel[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick(4'b0100, {5'h00, 5'h15, 5'h00, 5'h00}, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(4'b0001, {5'h00, 5'h00, 5'h00, 5'h11}, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 5'h15 || out_sel !== 2'd2 || obs_ready !== '0) begin
                errors++; $display("FAIL backpressure[%0d]: valid=%b data=%h rdy=%b, want 1/15/0000", i, out_valid, out_data, obs_ready);
            end
        end
        tick(4'b0001, {5'h00, 5'h00, 5'h00, 5'h11}, 1'b1);
        checks++;
        if (obs_ready !== 4'b0001 || out_valid !== 1'b1 || out_data !== 5'h11 || out_sel !== 2'd0) begin
            errors++; $display("FAIL bp_release: rdy=%b valid=%b data=%h sel=%0d, want 0001/1/11/0", obs_ready, out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_idle_drain();
        do_reset();
        tick(4'b0001, {5'h00, 5'h00, 5'h00, 5'h0A}, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 5'h0A) begin
            errors++; $display("FAIL drain_load: valid=%b data=%h, want 1/0a", out_valid, out_data);
        end
        tick(4'b0000, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 5'h0A || out_sel !== 2'd0 || obs_ready !== '0) begin
            errors++; $display("FAIL drain_idle: valid=%b data=%h sel=%0d, want 0/0a/0", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick(C'($urandom), (C*W)'({$urandom, $urandom}), 1'($urandom_range(0, 3) != 0));
            checks++;
            if (obs_ready !== exp_ready || out_valid !== m_valid || out_data !== m_data || out_sel !== m_sel) begin
                errors++; $display("FAIL random[%0d]: rdy=%b v=%b d=%h s=%0d, want %b/%b/%h/%0d", i, obs_ready, out_valid, out_data, out_sel, exp_ready, m_valid, m_data, m_sel);
            end
        end
    endtask

`ifdef RR_ARB_MUX_FORCE_SEL_EN
    task automatic test_force();
        logic [C*W-1:0] d;
        do_reset();
        d = {5'h04, 5'h03, 5'h02, 5'h01};
        tick(4'b1111, d, 1'b1);
        f_en = 1'b1; f_sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick(4'b1111, d, 1'b1);
            checks++;
            if (out_sel !== 2'd2 || out_data !== 5'h03 || obs_ready !== 4'b0100) begin
                errors++; $display("FAIL force[%0d]: sel=%0d data=%h rdy=%b, want 2/03/0100", i, out_sel, out_data, obs_ready);
            end
        end
        f_en = 1'b0;
        tick(4'b1111, d, 1'b1);
        checks++;
        if (out_sel !== 2'd1 || out_data !== 5'h02) begin
            errors++; $display("FAIL force_resume: sel=%0d data=%h, want 1/02", out_sel, out_data);
        end
        f_en = 1'b1; f_sel = 2'd0;
        tick(4'b1110, d, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || obs_ready !== '0) begin
            errors++; $display("FAIL force_idle: valid=%b rdy=%b, want 0/0000", out_valid, obs_ready);
        end
        f_en = 1'b0;
    endtask
`endif

    initial begin
        errors = 0; checks = 0;
        f_en = 1'b0; f_sel = '0;
        test_reset();
        test_all_valid();
        test_skip();
        test_backpressure();
        test_idle_drain();
`ifdef RR_ARB_MUX_FORCE_SEL_EN
        test_force();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
